spi_fsm_controller: RTL and testbench



---
 rtl/spi_fsm_controller.sv | 142 ++++++++++++++
 tb/tb_spi_fsm_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fsm_controller.sv
// Control FSM for the SPI memory slave: counts conditioned SCLK pulses, decodes the
// address/R-W byte and sequences the address latch, read load, write and MISO enable.
module spi_fsm_controller #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  sclkPosEdge,
  input  logic                  sclkNegEdge,
  input  logic                  csN,
  input  logic [DATA_WIDTH-1:0] shiftRegData,
  output logic                  addrWriteEnable,
  output logic                  srParallelLoad,
  output logic                  dmWriteEnable,
  output logic                  misoBufferEnable,
  output logic                  busy
);

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StAddrLatch,
    StReadWait,
    StReadLoad,
    StReadOut,
    StWriteIn,
    StWriteStore,
    StDone
  } state_e;

  localparam logic [3:0] CntLast  = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] WaitLast = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Only the R/W bit is decoded here; the address bits go straight to the address latch.
  logic unused_sr_bits;
  assign unused_sr_bits = ^shiftRegData[DATA_WIDTH-1:1];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!csN) begin
          state_d = StGetAddr;
          cnt_d   = 4'd0;
        end
      end
      StGetAddr: begin
        if (sclkPosEdge) begin
          if (cnt_q >= CntLast) begin
            state_d = StAddrLatch;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StAddrLatch: begin
        cnt_d = 4'd0;
        // Shift register updated on the 8th pulse edge, so bit 0 is valid here.
        if (shiftRegData[0]) begin
          state_d = (READ_LATENCY == 0) ? StReadLoad : StReadWait;
        end else begin
          state_d = StWriteIn;
        end
      end
      StReadWait: begin
        if (cnt_q >= WaitLast) begin
          state_d = StReadLoad;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StReadLoad: begin
        state_d = StReadOut;
        cnt_d   = 4'd0;
      end
      StReadOut: begin
        if (sclkNegEdge) begin
          if (cnt_q >= CntLast) begin
            state_d = StDone;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StWriteIn: begin
        if (sclkPosEdge) begin
          if (cnt_q >= CntLast) begin
            state_d = StWriteStore;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StWriteStore: begin
        state_d = StDone;
        cnt_d   = 4'd0;
      end
      StDone: begin
        if (csN) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase

    // Chip-select release aborts any transaction and overrides every other transition.
    if (state_q != StIdle && csN) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end
  end

  assign addrWriteEnable  = (state_q == StAddrLatch);
  assign srParallelLoad   = (state_q == StReadLoad);
  assign dmWriteEnable    = (state_q == StWriteStore);
  assign misoBufferEnable = (state_q == StReadOut);
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_spi_fsm_controller.sv
// Directed bench for spi_fsm_controller: READ_LATENCY=1 and READ_LATENCY=0 instances
// share stimulus; outputs are compared against hand-derived per-cycle values.
module tb_spi_fsm_controller;

  // Output vector encoding {busy, miso, dm, ld, aw}
  localparam int OIdle = 0;
  localparam int OBusy = 16;
  localparam int OAw   = 17;
  localparam int OLd   = 18;
  localparam int ODm   = 20;
  localparam int OMiso = 24;

  logic clk = 1'b0;
  logic resetN, sclkPosEdge, sclkNegEdge, csN, mosi;
  logic [7:0] sr;
  logic aw1, ld1, dm1, miso1, busy1;
  logic aw0, ld0, dm0, miso0, busy0;

  int n_checks = 0;
  int n_pass   = 0;
  int aw_cnt = 0, ld_cnt = 0, dm_cnt = 0, ld0_cnt = 0, dm0_cnt = 0;
  int aw_b, ld_b, dm_b, ld0_b, dm0_b;

  always #5 clk = ~clk;

  // Stand-in for the upstream shift register: shifts on the same edge as the pulse.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) sr <= 8'h00;
    else if (sclkPosEdge) sr <= {sr[6:0], mosi};
  end

  always @(negedge clk) begin
    if (aw1) aw_cnt++;
    if (ld1) ld_cnt++;
    if (dm1) dm_cnt++;
    if (ld0) ld0_cnt++;
    if (dm0) dm0_cnt++;
  end

  spi_fsm_controller #(.DATA_WIDTH(8), .READ_LATENCY(1)) u_dut (
    .clk              (clk),
    .resetN           (resetN),
    .sclkPosEdge      (sclkPosEdge),
    .sclkNegEdge      (sclkNegEdge),
    .csN              (csN),
    .shiftRegData     (sr),
    .addrWriteEnable  (aw1),
    .srParallelLoad   (ld1),
    .dmWriteEnable    (dm1),
    .misoBufferEnable (miso1),
    .busy             (busy1)
  );

  spi_fsm_controller #(.DATA_WIDTH(8), .READ_LATENCY(0)) u_dut0 (
    .clk              (clk),
    .resetN           (resetN),
    .sclkPosEdge      (sclkPosEdge),
    .sclkNegEdge      (sclkNegEdge),
    .csN              (csN),
    .shiftRegData     (sr),
    .addrWriteEnable  (aw0),
    .srParallelLoad   (ld0),
    .dmWriteEnable    (dm0),
    .misoBufferEnable (miso0),
    .busy             (busy0)
  );

  function automatic int outs1();
    return int'({busy1, miso1, dm1, ld1, aw1});
  endfunction

  function automatic int outs0();
    return int'({busy0, miso0, dm0, ld0, aw0});
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic p, input logic n, input logic b);
    mosi        = b;
    sclkPosEdge = p;
    sclkNegEdge = n;
    tick();
    sclkPosEdge = 1'b0;
    sclkNegEdge = 1'b0;
  endtask

  // MSB-first posedge pulses with a gap cycle between them; noise adds negedge pulses.
  task automatic shift_in(input logic [7:0] v, input int nbits, input logic noise);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) pulse(1'b0, noise, 1'b0);
      pulse(1'b1, noise, v[7-i]);
    end
  endtask

  task automatic shift_out(input int nbits, input logic noise);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) pulse(noise, 1'b0, 1'b0);
      pulse(noise, 1'b1, 1'b0);
    end
  endtask

  task automatic snap();
    aw_b = aw_cnt; ld_b = ld_cnt; dm_b = dm_cnt; ld0_b = ld0_cnt; dm0_b = dm0_cnt;
  endtask

  initial begin
    resetN = 1'b0; csN = 1'b1; sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; mosi = 1'b0;
    repeat (2) tick();
    check_eq("reset_outs", outs1(), OIdle);
    check_eq("reset_outs0", outs0(), OIdle);
    resetN = 1'b1;
    tick();
    check_eq("idle_cs_high", outs1(), OIdle);

    // Write: 0x54 = addr 0x2A, W; negedge noise during address phase
    snap();
    csN = 1'b0;
    tick();
    check_eq("wr_getaddr", outs1(), OBusy);
    shift_in(8'h54, 7, 1'b1);
    check_eq("wr_addr_7", outs1(), OBusy);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("wr_addr_latch", outs1(), OAw);
    tick();
    check_eq("wr_in", outs1(), OBusy);
    shift_in(8'hA5, 7, 1'b1);
    check_eq("wr_in_7", outs1(), OBusy);
    pulse(1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check_eq("wr_store", outs1(), ODm);
    tick();
    check_eq("wr_done", outs1(), OBusy);
    shift_in(8'hFF, 3, 1'b1);
    check_eq("wr_done_extra", outs1(), OBusy);
    csN = 1'b1;
    tick();
    check_eq("wr_idle", outs1(), OIdle);
    check_eq("wr_aw_once", aw_cnt - aw_b, 1);
    check_eq("wr_dm_once", dm_cnt - dm_b, 1);
    check_eq("wr_no_ld", ld_cnt - ld_b, 0);
    check_eq("wr_dm_once0", dm0_cnt - dm0_b, 1);

    // Read back-to-back: 0x55 = addr 0x2A, R
    snap();
    csN = 1'b0;
    tick();
    check_eq("rd_getaddr", outs1(), OBusy);
    shift_in(8'h55, 8, 1'b1);
    check_eq("rd_addr_latch", outs1(), OAw);
    check_eq("rd_addr_latch0", outs0(), OAw);
    tick();
    check_eq("rd_wait", outs1(), OBusy);
    check_eq("rd_load0", outs0(), OLd);
    tick();
    check_eq("rd_load", outs1(), OLd);
    check_eq("rd_out0", outs0(), OMiso);
    tick();
    check_eq("rd_out", outs1(), OMiso);
    shift_out(7, 1'b1);
    check_eq("rd_out_7", outs1(), OMiso);
    check_eq("rd_out_7_0", outs0(), OMiso);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_eq("rd_done", outs1(), OBusy);
    check_eq("rd_done0", outs0(), OBusy);
    csN = 1'b1;
    tick();
    check_eq("rd_idle", outs1(), OIdle);
    check_eq("rd_aw_once", aw_cnt - aw_b, 1);
    check_eq("rd_ld_once", ld_cnt - ld_b, 1);
    check_eq("rd_ld_once0", ld0_cnt - ld0_b, 1);
    check_eq("rd_no_dm", dm_cnt - dm_b, 0);

    // Abort after 5 write-data pulses, then a fresh read
    snap();
    csN = 1'b0;
    tick();
    shift_in(8'h54, 8, 1'b0);
    check_eq("ab_latch", outs1(), OAw);
    tick();
    check_eq("ab_wr_in", outs1(), OBusy);
    shift_in(8'hF0, 5, 1'b0);
    check_eq("ab_5", outs1(), OBusy);
    csN = 1'b1;
    tick();
    check_eq("ab_idle", outs1(), OIdle);
    check_eq("ab_idle0", outs0(), OIdle);
    repeat (2) tick();
    check_eq("ab_no_dm", dm_cnt - dm_b, 0);
    csN = 1'b0;
    tick();
    check_eq("ab_new_getaddr", outs1(), OBusy);
    shift_in(8'h55, 8, 1'b0);
    check_eq("ab_new_latch", outs1(), OAw);
    tick();
    check_eq("ab_new_load0", outs0(), OLd);
    tick();
    check_eq("ab_new_load", outs1(), OLd);
    csN = 1'b1;
    tick();
    check_eq("ab_new_idle", outs1(), OIdle);

    // Asynchronous reset in WRITE_IN after 3 pulses
    csN = 1'b0;
    tick();
    shift_in(8'h54, 8, 1'b0);
    tick();
    shift_in(8'hFF, 3, 1'b0);
    check_eq("rst_pre", outs1(), OBusy);
    #2 resetN = 1'b0;
    #1;
    check_eq("rst_async", outs1(), OIdle);
    check_eq("rst_async0", outs0(), OIdle);
    resetN = 1'b1;
    tick();
    check_eq("rst_getaddr", outs1(), OBusy);
    shift_in(8'h55, 7, 1'b0);
    check_eq("rst_7", outs1(), OBusy);
    pulse(1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check_eq("rst_latch", outs1(), OAw);
    csN = 1'b1;
    tick();
    check_eq("rst_idle", outs1(), OIdle);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
